// File: rtl/parity_bus_pkg.sv
// Shared types and helpers for the parity byte bus arbiter.
// State encoding, word geometry and the beat/parity formatter.
package parity_bus_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BEATS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    FINISH,
    ABORT
  } state_t;

  function automatic logic parity8(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

  // Beat 0 carries the most significant byte.
  function automatic logic [BYTE_W:0] beat_of(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        idx
  );
    logic [BYTE_W-1:0] b;
    unique case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return {b, parity8(b)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module rr_arbiter
  import parity_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        gnt_idx                   = cand[IDX_W-1:0];
        gnt_oh[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_bus_arbiter.sv
// Round-robin owner of the 9-bit parity byte bus; sends 4 beats per word.
// Optional ARB_RETRY_EN: one START retry after the first timeout.
module parity_bus_arbiter
  import parity_bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic                    busy,
  output logic                    bus_ready,
  input  logic                    bus_ack,
  output logic [8:0]              bus_data,
  input  logic                    bus_beat_ack,
  output logic [1:0]              beat_idx
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                bus_ready_q, bus_ready_d;
  logic [8:0]          bus_data_q, bus_data_d;
  logic [1:0]          beat_q, beat_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [WORD_W-1:0]   word_q, word_d;
`ifdef ARB_RETRY_EN
  logic                retry_q, retry_d;
`endif

  logic [NUM_REQ-1:0]  arb_oh;
  logic [IDX_W-1:0]    arb_idx;
  logic [WORD_W-1:0]   arb_word;
  logic                tmo_hit;
  logic                tmo_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1))
      return '0;
    return i + IDX_W'(1);
  endfunction

  always_comb begin
    arb_word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_oh[i])
        arb_word = req_data[i*WORD_W +: WORD_W];
  end

  assign tmo_hit = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    bus_ready_d = bus_ready_q;
    bus_data_d  = bus_data_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    tmo_d       = tmo_q;
    word_d      = word_q;
    tmo_fire    = 1'b0;
`ifdef ARB_RETRY_EN
    retry_d     = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = START;
          gnt_d       = arb_oh;
          idx_d       = arb_idx;
          word_d      = arb_word;
          bus_ready_d = 1'b1;
          tmo_d       = '0;
        end
      end
      START: begin
        if (bus_ack) begin
          state_d     = SEND;
          bus_ready_d = 1'b0;
          beat_d      = 2'd0;
          bus_data_d  = beat_of(word_q, 2'd0);
          tmo_d       = '0;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      SEND: begin
        if (bus_beat_ack) begin
          tmo_d = '0;
          if (beat_q == 2'(BEATS - 1)) begin
            state_d    = FINISH;
            done_d     = gnt_q;
            gnt_d      = '0;
            bus_data_d = '0;
            beat_d     = 2'd0;
            rr_d       = next_ptr(idx_q);
          end else begin
            beat_d     = beat_q + 2'd1;
            bus_data_d = beat_of(word_q, beat_q + 2'd1);
          end
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tmo_fire) begin
`ifdef ARB_RETRY_EN
      if (!retry_q) begin
        retry_d     = 1'b1;
        state_d     = START;
        bus_ready_d = 1'b1;
        bus_data_d  = '0;
        beat_d      = 2'd0;
        tmo_d       = '0;
      end else
`endif
      begin
        state_d     = ABORT;
        err_d       = 1'b1;
        gnt_d       = '0;
        bus_ready_d = 1'b0;
        bus_data_d  = '0;
        beat_d      = 2'd0;
        tmo_d       = '0;
        rr_d        = next_ptr(idx_q);
      end
    end

`ifdef ARB_RETRY_EN
    if (state_d == FINISH || state_d == ABORT)
      retry_d = 1'b0;
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      bus_ready_q <= 1'b0;
      bus_data_q  <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      rr_q        <= '0;
      tmo_q       <= '0;
      word_q      <= '0;
`ifdef ARB_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      bus_ready_q <= bus_ready_d;
      bus_data_q  <= bus_data_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      tmo_q       <= tmo_d;
      word_q      <= word_d;
`ifdef ARB_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign bus_ready = bus_ready_q;
  assign bus_data  = bus_data_q;
  assign beat_idx  = beat_q;

endmodule

// File: tb/tb_parity_bus_arbiter.sv
// Directed bench for parity_bus_arbiter: vector table plus
// hand-written contention, timeout, stall and reset sequences.
module tb_parity_bus_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            err;
  logic            busy;
  logic            bus_ready;
  logic            bus_ack;
  logic [8:0]      bus_data;
  logic            bus_beat_ack;
  logic [1:0]      beat_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_bus_arbiter #(
    .NUM_REQ     (N),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .bus_ready    (bus_ready),
    .bus_ack      (bus_ack),
    .bus_data     (bus_data),
    .bus_beat_ack (bus_beat_ack),
    .beat_idx     (beat_idx)
  );

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic         back;
    logic [18:0]  exp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [18:0] e(
    input logic [1:0] g, input logic [1:0] d, input logic er,
    input logic bz, input logic rd, input logic [8:0] dt,
    input logic [1:0] bt
  );
    return {g, d, er, bz, rd, dt, bt};
  endfunction

  function automatic logic [18:0] snap();
    return {gnt, done, err, busy, bus_ready, bus_data, beat_idx};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req          = '0;
    bus_ack      = 1'b0;
    bus_beat_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // sel: 0 gnt!=0, 1 done!=0
  task automatic wait_for(input int sel, input int lim, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if ((sel == 0 && gnt != '0) || (sel == 1 && done != '0)) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out after %0d cycles, expected event", nm, lim);
    end
  endtask

  logic [N-1:0] exp_g;
  logic [8:0]   exp_b0;
  int           n;
  bit           done_seen;

  initial begin
    req_data = {32'h1234_5678, 32'hA53C_FF01};

    tbl[0] = '{2'b01, 1'b1, 1'b1, e(2'b01, 2'b00, 0, 1, 1, 9'h000, 2'd0)};
    tbl[1] = '{2'b00, 1'b1, 1'b1, e(2'b01, 2'b00, 0, 1, 0, 9'h14A, 2'd0)};
    tbl[2] = '{2'b00, 1'b1, 1'b1, e(2'b01, 2'b00, 0, 1, 0, 9'h078, 2'd1)};
    tbl[3] = '{2'b00, 1'b1, 1'b1, e(2'b01, 2'b00, 0, 1, 0, 9'h1FE, 2'd2)};
    tbl[4] = '{2'b00, 1'b1, 1'b1, e(2'b01, 2'b00, 0, 1, 0, 9'h003, 2'd3)};
    tbl[5] = '{2'b00, 1'b1, 1'b1, e(2'b00, 2'b01, 0, 1, 0, 9'h000, 2'd0)};
    tbl[6] = '{2'b00, 1'b1, 1'b1, e(2'b00, 2'b00, 0, 0, 0, 9'h000, 2'd0)};

    // reset values and quiet idle
    do_reset();
    chk("reset_state", 32'(snap()), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", {29'h0, |gnt, busy, bus_ready}, 32'h0);
    end

    // single transfer from the vector table
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req          = tbl[i].req;
      bus_ack      = tbl[i].ack;
      bus_beat_ack = tbl[i].back;
      tick();
      chk($sformatf("single_v%0d", i), 32'(snap()), 32'(tbl[i].exp));
    end

    // contention: both held high, grants alternate 0,1,0,1
    do_reset();
    req          = 2'b11;
    bus_ack      = 1'b1;
    bus_beat_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_b0 = (k % 2 == 0) ? 9'h14A : 9'h024;
      wait_for(0, 20, "contend_gnt_wait");
      chk($sformatf("contend_gnt%0d", k), 32'(gnt), 32'(exp_g));
      tick();
      chk($sformatf("contend_beat0_%0d", k), 32'(bus_data), 32'(exp_b0));
      wait_for(1, 20, "contend_done_wait");
      chk($sformatf("contend_done%0d", k), {28'h0, done, gnt}, {28'h0, exp_g, 2'b00});
      tick();
    end

    // ack timeout then fairness
    do_reset();
    req = 2'b01;
    tick();
    n         = 0;
    done_seen = 1'b0;
    while (!err && n < 80) begin
      tick();
      n++;
      done_seen |= |done;
`ifdef ARB_RETRY_EN
      if (n == TMO)
        chk("retry_restart", {29'h0, bus_ready, err, gnt[0]}, 32'h5);
`endif
    end
`ifdef ARB_RETRY_EN
    chk("timeout_latency", 32'(n), 32'(2 * TMO));
`else
    chk("timeout_latency", 32'(n), 32'(TMO));
`endif
    chk("timeout_state", {28'h0, gnt, bus_ready, done_seen}, 32'h0);
    req          = 2'b11;
    bus_ack      = 1'b1;
    bus_beat_ack = 1'b1;
    tick();
    chk("timeout_err_pulse", {31'h0, err}, 32'h0);
    wait_for(0, 20, "timeout_next_wait");
    chk("timeout_next_gnt", 32'(gnt), 32'h2);
    wait_for(1, 20, "timeout_next_done");
    chk("timeout_next_done", 32'(done), 32'h2);

    // beat stall on beat 1 and req drop at beat 2
    do_reset();
    req          = 2'b01;
    bus_ack      = 1'b1;
    bus_beat_ack = 1'b0;
    tick();
    tick();
    chk("stall_beat0", {21'h0, bus_data, beat_idx}, {21'h0, 9'h14A, 2'd0});
    bus_beat_ack = 1'b1;
    tick();
    chk("stall_beat1", {21'h0, bus_data, beat_idx}, {21'h0, 9'h078, 2'd1});
    bus_beat_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", {20'h0, err, bus_data, beat_idx}, {21'h0, 9'h078, 2'd1});
    end
    bus_beat_ack = 1'b1;
    tick();
    chk("stall_beat2", {21'h0, bus_data, beat_idx}, {21'h0, 9'h1FE, 2'd2});
    req = 2'b00;
    tick();
    chk("stall_beat3", {21'h0, bus_data, beat_idx}, {21'h0, 9'h003, 2'd3});
    tick();
    chk("drop_done", {28'h0, done, gnt}, {28'h0, 2'b01, 2'b00});
    tick();
    chk("drop_idle", {30'h0, busy, |done}, 32'h0);

    // reset in SEND at beat 2
    do_reset();
    req          = 2'b01;
    bus_ack      = 1'b1;
    bus_beat_ack = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("rst_pre_beat2", {21'h0, bus_data, beat_idx}, {21'h0, 9'h1FE, 2'd2});
    rst = 1'b1;
    tick();
    chk("rst_mid_send", 32'(snap()), 32'h0);
    rst = 1'b0;
    req = 2'b00;
    tick();
    chk("rst_no_late_pulse", 32'(snap()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
